// File: rtl/brick_hit_controller.sv
// Brick-field state for a 4x4 breakout grid: once per frame, scans the bricks in
// order for the first one the ball touches, then damages it and reports the bounce.
module brick_hit_controller #(
   parameter int GRID_X0   = 112,
   parameter int GRID_Y0   = 80,
   parameter int B_WIDTH   = 128,
   parameter int B_HEIGHT  = 32,
   parameter int B_GAP     = 16,
   parameter int BALL_R    = 10,
   parameter int HITS_INIT = 1
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        level_load,
   input  logic [11:0] x_pos,
   input  logic [11:0] y_pos,
   output logic [15:0] blocks_out,
   output logic        hit_valid,
   output logic [3:0]  hit_index,
   output logic        bounce_x,
   output logic        bounce_y,
   output logic [7:0]  score,
   output logic        all_cleared,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, HIT = 2'd2} state_t;

   localparam logic [1:0]  HEALTH_INIT = 2'(HITS_INIT);
   localparam logic [12:0] BALL        = 13'(BALL_R);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [11:0] x_lat_q, x_lat_d;
   logic [11:0] y_lat_q, y_lat_d;
   logic [1:0]  health_q [16];
   logic [1:0]  health_d [16];
   logic [15:0] blocks_q, blocks_d;
   logic [7:0]  score_q, score_d;
   logic        hit_valid_q, hit_valid_d;
   logic [3:0]  hit_index_q, hit_index_d;
   logic        bounce_x_q, bounce_x_d;
   logic        bounce_y_q, bounce_y_d;
   logic        all_cleared_q, all_cleared_d;

   // Brick rectangles are fixed by the parameters, so they reduce to constants.
   logic [12:0] brick_l [16];
   logic [12:0] brick_r [16];
   logic [12:0] brick_t [16];
   logic [12:0] brick_b [16];

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_geom
         localparam int COL = gi % 4;
         localparam int ROW = gi / 4;
         assign brick_l[gi] = 13'(GRID_X0 + COL * (B_WIDTH + B_GAP));
         assign brick_r[gi] = 13'(GRID_X0 + COL * (B_WIDTH + B_GAP) + B_WIDTH);
         assign brick_t[gi] = 13'(GRID_Y0 + ROW * (B_HEIGHT + B_GAP));
         assign brick_b[gi] = 13'(GRID_Y0 + ROW * (B_HEIGHT + B_GAP) + B_HEIGHT);
      end
   endgenerate

   logic [12:0] x13, y13;
   logic [12:0] ball_x_lo, ball_x_hi, ball_y_lo, ball_y_hi;
   logic        x_inside, y_inside, x_overlap, y_overlap, brick_hit;

   always_comb begin
      x13       = {1'b0, x_lat_q};
      y13       = {1'b0, y_lat_q};
      ball_x_lo = (x13 < BALL) ? 13'd0 : x13 - BALL;
      ball_x_hi = x13 + BALL;
      ball_y_lo = (y13 < BALL) ? 13'd0 : y13 - BALL;
      ball_y_hi = y13 + BALL;
      x_inside  = (x13 >= brick_l[idx_q]) && (x13 <= brick_r[idx_q]);
      y_inside  = (y13 >= brick_t[idx_q]) && (y13 <= brick_b[idx_q]);
      x_overlap = (ball_x_lo <= brick_r[idx_q]) && (ball_x_hi >= brick_l[idx_q]);
      y_overlap = (ball_y_lo <= brick_b[idx_q]) && (ball_y_hi >= brick_t[idx_q]);
      brick_hit = (health_q[idx_q] != 2'd0) && x_overlap && y_overlap;
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      x_lat_d       = x_lat_q;
      y_lat_d       = y_lat_q;
      health_d      = health_q;
      blocks_d      = blocks_q;
      score_d       = score_q;
      hit_valid_d   = 1'b0;
      hit_index_d   = hit_index_q;
      bounce_x_d    = bounce_x_q;
      bounce_y_d    = bounce_y_q;
      all_cleared_d = (blocks_q == 16'hFFFF);

      case (state_q)
         IDLE: begin
            if (frame_tick) begin
               x_lat_d = x_pos;
               y_lat_d = y_pos;
               idx_d   = 4'd0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (brick_hit) begin
               // Event flags are registered here so they are visible during HIT.
               hit_valid_d = 1'b1;
               hit_index_d = idx_q;
               if (x_inside) begin
                  bounce_x_d = 1'b0;
                  bounce_y_d = 1'b1;
               end else if (y_inside) begin
                  bounce_x_d = 1'b1;
                  bounce_y_d = 1'b0;
               end else begin
                  bounce_x_d = 1'b1;
                  bounce_y_d = 1'b1;
               end
               state_d = HIT;
            end else if (idx_q == 4'd15) begin
               state_d = IDLE;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         HIT: begin
            state_d = IDLE;
            if (health_q[hit_index_q] != 2'd0) begin
               health_d[hit_index_q] = health_q[hit_index_q] - 2'd1;
               if (health_q[hit_index_q] == 2'd1) begin
                  blocks_d[hit_index_q] = 1'b1;
                  if (score_q != 8'hFF) begin
                     score_d = score_q + 8'd1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (level_load) begin
         for (int i = 0; i < 16; i++) begin
            health_d[i] = HEALTH_INIT;
         end
         blocks_d      = 16'h0000;
         score_d       = 8'd0;
         hit_valid_d   = 1'b0;
         all_cleared_d = 1'b0;
         state_d       = IDLE;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q       <= IDLE;
         idx_q         <= 4'd0;
         x_lat_q       <= 12'd0;
         y_lat_q       <= 12'd0;
         for (int i = 0; i < 16; i++) begin
            health_q[i] <= HEALTH_INIT;
         end
         blocks_q      <= 16'h0000;
         score_q       <= 8'd0;
         hit_valid_q   <= 1'b0;
         hit_index_q   <= 4'd0;
         bounce_x_q    <= 1'b0;
         bounce_y_q    <= 1'b0;
         all_cleared_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         x_lat_q       <= x_lat_d;
         y_lat_q       <= y_lat_d;
         for (int i = 0; i < 16; i++) begin
            health_q[i] <= health_d[i];
         end
         blocks_q      <= blocks_d;
         score_q       <= score_d;
         hit_valid_q   <= hit_valid_d;
         hit_index_q   <= hit_index_d;
         bounce_x_q    <= bounce_x_d;
         bounce_y_q    <= bounce_y_d;
         all_cleared_q <= all_cleared_d;
      end
   end

   assign blocks_out  = blocks_q;
   assign hit_valid   = hit_valid_q;
   assign hit_index   = hit_index_q;
   assign bounce_x    = bounce_x_q;
   assign bounce_y    = bounce_y_q;
   assign score       = score_q;
   assign all_cleared = all_cleared_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_brick_hit_controller.sv
// Self-checking bench for brick_hit_controller: directed scenarios plus random
// frames checked against a loop-based geometric reference model.
module tb_brick_hit_controller;

   localparam int GX0 = 112, GY0 = 80, BW = 128, BH = 32, GAP = 16, BR = 10;

   logic        pclk = 1'b0;
   logic        rst, frame_tick, level_load, use2;
   logic [11:0] x_pos, y_pos;
   logic [15:0] blocks_out, blocks2;
   logic        hit_valid, bounce_x, bounce_y, all_cleared, busy;
   logic        hit_valid2, bounce_x2, bounce_y2, all_cleared2, busy2;
   logic [3:0]  hit_index, hit_index2;
   logic [7:0]  score, score2;

   int errors = 0;
   int checks = 0;

   brick_hit_controller dut (
      .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .level_load(level_load),
      .x_pos(x_pos), .y_pos(y_pos), .blocks_out(blocks_out), .hit_valid(hit_valid),
      .hit_index(hit_index), .bounce_x(bounce_x), .bounce_y(bounce_y), .score(score),
      .all_cleared(all_cleared), .busy(busy)
   );

   brick_hit_controller #(.HITS_INIT(2)) dut2 (
      .pclk(pclk), .rst(rst), .frame_tick(frame_tick & use2), .level_load(level_load),
      .x_pos(x_pos), .y_pos(y_pos), .blocks_out(blocks2), .hit_valid(hit_valid2),
      .hit_index(hit_index2), .bounce_x(bounce_x2), .bounce_y(bounce_y2), .score(score2),
      .all_cleared(all_cleared2), .busy(busy2)
   );

   always #5 pclk = ~pclk;

   // Results of the most recent frame
   int r_hv, r_cyc, r_idx, r_bx, r_by, r_busy;
   int r2_hv, r2_cyc, r2_idx, r2_bx, r2_by;

   // Reference model state
   int          m_health [16];
   logic [15:0] m_blocks;
   int          m_score;

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_health[i] = 1;
      m_blocks = 16'h0000;
      m_score  = 0;
   endtask

   task automatic model_frame(input int x, input int y,
                              output int hit, output int idx, output int bx, output int by);
      int xl, xh, yl, yh, l, r, t, b;
      xl = (x < BR) ? 0 : x - BR;
      xh = x + BR;
      yl = (y < BR) ? 0 : y - BR;
      yh = y + BR;
      hit = 0; idx = 0; bx = 0; by = 0;
      for (int i = 0; i < 16; i++) begin
         l = GX0 + (i % 4) * (BW + GAP);  r = l + BW;
         t = GY0 + (i / 4) * (BH + GAP);  b = t + BH;
         if (hit == 0 && m_health[i] > 0 && xl <= r && xh >= l && yl <= b && yh >= t) begin
            hit = 1;
            idx = i;
            if (x >= l && x <= r) begin bx = 0; by = 1; end
            else if (y >= t && y <= b) begin bx = 1; by = 0; end
            else begin bx = 1; by = 1; end
         end
      end
      if (hit != 0) begin
         m_health[idx]--;
         if (m_health[idx] == 0) begin
            m_blocks[idx] = 1'b1;
            if (m_score < 255) m_score++;
         end
      end
   endtask

   task automatic do_level_load();
      level_load = 1'b1;
      tick();
      level_load = 1'b0;
      model_reset();
   endtask

   // Pulses frame_tick and observes both DUTs until they return to idle.
   task automatic run_frame(input int x, input int y);
      int c;
      bit done;
      x_pos = 12'(x);
      y_pos = 12'(y);
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      r_hv = 0; r_cyc = 0; r_idx = 0; r_bx = 0; r_by = 0; r_busy = 0;
      r2_hv = 0; r2_cyc = 0; r2_idx = 0; r2_bx = 0; r2_by = 0;
      c = 1;
      done = 1'b0;
      while (!done && c <= 24) begin
         if (busy) r_busy++;
         if (hit_valid) begin
            r_hv++; r_cyc = c; r_idx = hit_index; r_bx = bounce_x; r_by = bounce_y;
         end
         if (hit_valid2) begin
            r2_hv++; r2_cyc = c; r2_idx = hit_index2; r2_bx = bounce_x2; r2_by = bounce_y2;
         end
         if (!busy && !busy2) done = 1'b1;
         else begin
            tick();
            c++;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL frame_timeout: got busy still high after %0d cycles, expected idle", c);
      end
      $display("frame x=%0d y=%0d hits=%0d idx=%0d cyc=%0d bx=%0d by=%0d busy=%0d blocks=%h score=%0d",
               x, y, r_hv, r_idx, r_cyc, r_bx, r_by, r_busy, blocks_out, score);
   endtask

   task automatic test_reset();
      rst = 1'b1; frame_tick = 1'b0; level_load = 1'b0; use2 = 1'b0;
      x_pos = 12'd0; y_pos = 12'd0;
      repeat (3) tick();
      rst = 1'b0;
      model_reset();
      checks++;
      if ({blocks_out, score, hit_valid, hit_index, bounce_x, bounce_y, all_cleared, busy} !== 33'd0) begin
         errors++;
         $display("FAIL reset_outputs: got blocks=%h score=%0d hv=%b idx=%0d bx=%b by=%b clr=%b busy=%b, expected all 0",
                  blocks_out, score, hit_valid, hit_index, bounce_x, bounce_y, all_cleared, busy);
      end
   endtask

   task automatic test_first_hit();
      run_frame(176, 116);
      checks++;
      if (r_hv !== 1 || r_cyc !== 2 || r_idx !== 0) begin
         errors++;
         $display("FAIL first_hit_event: got hv=%0d cyc=%0d idx=%0d, expected 1/2/0", r_hv, r_cyc, r_idx);
      end
      checks++;
      if (r_bx !== 0 || r_by !== 1) begin
         errors++;
         $display("FAIL first_hit_bounce: got bx=%0d by=%0d, expected 0/1", r_bx, r_by);
      end
      checks++;
      if (r_busy !== 2) begin
         errors++;
         $display("FAIL first_hit_busy: got %0d cycles, expected 2", r_busy);
      end
      checks++;
      if (blocks_out !== 16'h0001 || score !== 8'd1) begin
         errors++;
         $display("FAIL first_hit_state: got blocks=%h score=%0d, expected 0001/1", blocks_out, score);
      end
   endtask

   task automatic test_miss_repeat();
      run_frame(176, 116);
      checks++;
      if (r_hv !== 0 || r_busy !== 16) begin
         errors++;
         $display("FAIL miss_scan: got hv=%0d busy=%0d, expected 0/16", r_hv, r_busy);
      end
      checks++;
      if (blocks_out !== 16'h0001 || score !== 8'd1) begin
         errors++;
         $display("FAIL miss_state: got blocks=%h score=%0d, expected 0001/1", blocks_out, score);
      end
   endtask

   task automatic test_two_hit();
      do_level_load();
      use2 = 1'b1;
      run_frame(248, 144);
      checks++;
      if (r2_hv !== 1 || r2_idx !== 4 || r2_cyc !== 6 || r2_bx !== 1 || r2_by !== 0) begin
         errors++;
         $display("FAIL two_hit_first: got hv=%0d idx=%0d cyc=%0d bx=%0d by=%0d, expected 1/4/6/1/0",
                  r2_hv, r2_idx, r2_cyc, r2_bx, r2_by);
      end
      checks++;
      if (blocks2 !== 16'h0000 || score2 !== 8'd0) begin
         errors++;
         $display("FAIL two_hit_survive: got blocks=%h score=%0d, expected 0000/0", blocks2, score2);
      end
      run_frame(248, 144);
      checks++;
      if (r2_idx !== 4 || blocks2 !== 16'h0010 || score2 !== 8'd1) begin
         errors++;
         $display("FAIL two_hit_destroy: got idx=%0d blocks=%h score=%0d, expected 4/0010/1",
                  r2_idx, blocks2, score2);
      end
      checks++;
      if (r_idx !== 5 || r_cyc !== 7) begin
         errors++;
         $display("FAIL one_hit_next_brick: got idx=%0d cyc=%0d, expected 5/7", r_idx, r_cyc);
      end
      use2 = 1'b0;
   endtask

   task automatic test_corner();
      do_level_load();
      run_frame(245, 75);
      checks++;
      if (r_hv !== 1 || r_idx !== 0 || r_bx !== 1 || r_by !== 1) begin
         errors++;
         $display("FAIL corner_hit: got hv=%0d idx=%0d bx=%0d by=%0d, expected 1/0/1/1", r_hv, r_idx, r_bx, r_by);
      end
      run_frame(245, 75);
      checks++;
      if (r_hv !== 0 || r_busy !== 16) begin
         errors++;
         $display("FAIL corner_no_brick1: got hv=%0d busy=%0d, expected 0/16", r_hv, r_busy);
      end
   endtask

   task automatic test_ignore_and_abort();
      int c, hv, bc, last;
      do_level_load();
      x_pos = 12'd320; y_pos = 12'd192;
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      hv = 0; bc = 0; last = 0;
      for (c = 1; c <= 20; c++) begin
         if (busy) bc++;
         if (hit_valid) begin hv++; last = c; end
         frame_tick = (c == 5);
         tick();
      end
      frame_tick = 1'b0;
      checks++;
      if (hv !== 1 || last !== 11 || bc !== 11) begin
         errors++;
         $display("FAIL ignore_tick: got hits=%0d cyc=%0d busy=%0d, expected 1/11/11", hv, last, bc);
      end
      $display("frame x=320 y=192 (extra tick at T0+5) hits=%0d cyc=%0d busy=%0d", hv, last, bc);

      run_frame(176, 116);
      x_pos = 12'd320; y_pos = 12'd192;
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
      tick();
      level_load = 1'b1;
      tick();
      level_load = 1'b0;
      checks++;
      if (busy !== 1'b0 || blocks_out !== 16'h0000 || score !== 8'd0 || hit_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: got busy=%b blocks=%h score=%0d hv=%b, expected 0/0000/0/0",
                  busy, blocks_out, score, hit_valid);
      end
      hv = 0;
      for (int k = 0; k < 16; k++) begin
         if (hit_valid || busy) hv++;
         tick();
      end
      checks++;
      if (hv !== 0) begin
         errors++;
         $display("FAIL abort_quiet: got %0d active cycles after abort, expected 0", hv);
      end
      $display("abort at T0+3 active_after=%0d blocks=%h", hv, blocks_out);
      model_reset();
   endtask

   task automatic test_random();
      int x, y, eh, ei, ebx, eby, eb;
      do_level_load();
      for (int n = 0; n < 60; n++) begin
         x = (n % 10 == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(80, 760));
         y = int'($urandom_range(40, 300));
         model_frame(x, y, eh, ei, ebx, eby);
         run_frame(x, y);
         eb = (eh != 0) ? ei + 2 : 16;
         checks++;
         if (r_hv !== eh || r_busy !== eb) begin
            errors++;
            $display("FAIL rand_event: got hv=%0d busy=%0d, expected %0d/%0d", r_hv, r_busy, eh, eb);
         end
         if (eh != 0) begin
            checks++;
            if (r_idx !== ei || r_cyc !== ei + 2 || r_bx !== ebx || r_by !== eby) begin
               errors++;
               $display("FAIL rand_hit: got idx=%0d cyc=%0d bx=%0d by=%0d, expected %0d/%0d/%0d/%0d",
                        r_idx, r_cyc, r_bx, r_by, ei, ei + 2, ebx, eby);
            end
         end
         checks++;
         if (blocks_out !== m_blocks || score !== 8'(m_score)) begin
            errors++;
            $display("FAIL rand_state: got blocks=%h score=%0d, expected %h/%0d",
                     blocks_out, score, m_blocks, m_score);
         end
      end
   endtask

   task automatic test_clear_all();
      do_level_load();
      for (int i = 0; i < 16; i++) begin
         run_frame(GX0 + (i % 4) * (BW + GAP) + BW / 2, GY0 + (i / 4) * (BH + GAP) + BH / 2);
         checks++;
         if (r_hv !== 1 || r_idx !== i) begin
            errors++;
            $display("FAIL clear_hit: got hv=%0d idx=%0d, expected 1/%0d", r_hv, r_idx, i);
         end
      end
      checks++;
      if (blocks_out !== 16'hFFFF || score !== 8'd16 || all_cleared !== 1'b0) begin
         errors++;
         $display("FAIL clear_final: got blocks=%h score=%0d clr=%b, expected FFFF/16/0",
                  blocks_out, score, all_cleared);
      end
      tick();
      checks++;
      if (all_cleared !== 1'b1) begin
         errors++;
         $display("FAIL clear_flag_rise: got %b, expected 1", all_cleared);
      end
      run_frame(GX0 + BW / 2, GY0 + BH / 2);
      checks++;
      if (r_hv !== 0 || r_busy !== 16 || all_cleared !== 1'b1) begin
         errors++;
         $display("FAIL cleared_scan: got hv=%0d busy=%0d clr=%b, expected 0/16/1", r_hv, r_busy, all_cleared);
      end
      do_level_load();
      checks++;
      if (all_cleared !== 1'b0 || blocks_out !== 16'h0000 || score !== 8'd0) begin
         errors++;
         $display("FAIL clear_reload: got clr=%b blocks=%h score=%0d, expected 0/0000/0",
                  all_cleared, blocks_out, score);
      end
   endtask

   initial begin
      test_reset();
      test_first_hit();
      test_miss_repeat();
      test_two_hit();
      test_corner();
      test_ignore_and_abort();
      test_random();
      test_clear_all();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
